// File: rtl/popcount_acc_sequencer_if.sv
// rtl/popcount_acc_sequencer_if.sv - input beat and result streams of the popcount frame sequencer
interface popcount_acc_sequencer_if #(
    parameter int NO_CH  = 64,
    parameter int BW_IN  = 12,
    parameter int BW_OUT = 16
);
    logic                      in_vld;
    logic [NO_CH*BW_IN-1:0]    in_data;
    logic                      in_rdy;
    logic                      out_vld;
    logic [NO_CH*BW_OUT-1:0]   out_data;
    logic                      out_last;
    logic                      out_rdy;

    // master is the sequencer side: it consumes beats and produces results
    modport master (
        input  in_vld, in_data, out_rdy,
        output in_rdy, out_vld, out_data, out_last
    );

    modport slave (
        output in_vld, in_data, out_rdy,
        input  in_rdy, out_vld, out_data, out_last
    );
endinterface

// File: rtl/popcount_acc_sequencer.sv
// rtl/popcount_acc_sequencer.sv - feeds whole frames to the popcount accumulator and holds each result
module popcount_acc_sequencer #(
    parameter int NO_CH       = 64,
    parameter int BW_IN       = 12,
    parameter int BW_OUT      = 16,
    parameter int CYC_ACC     = 4,
    parameter int FRAME_CNT_W = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic [FRAME_CNT_W-1:0]    num_frames,
    input  logic                      abort,
    output logic                      busy,
    output logic                      done_pulse,
    output logic                      err,
    output logic                      acc_rst,
    output logic                      acc_vld_in,
    output logic [NO_CH*BW_IN-1:0]    acc_data_in,
    input  logic                      acc_vld_out,
    input  logic [NO_CH*BW_OUT-1:0]   acc_data_out,
    popcount_acc_sequencer_if.master  bus
);
    localparam int BCW = (CYC_ACC > 1) ? $clog2(CYC_ACC) : 1;
    localparam logic [BCW-1:0] BEAT_LAST = BCW'(CYC_ACC - 1);

    typedef enum logic {IDLE, RUN} state_t;

    state_t                    state;
    logic [BCW-1:0]            beat_cnt;
    logic [FRAME_CNT_W-1:0]    num_lat;
    logic [FRAME_CNT_W-1:0]    frames_issued;
    logic [FRAME_CNT_W-1:0]    frames_done;
    logic                      res_pend;
    logic                      out_vld_r;
    logic                      out_last_r;
    logic [NO_CH*BW_OUT-1:0]   out_data_r;

    logic stall;
    logic in_rdy_c;
    logic accept;
    logic capture;
    logic pop;

    // the last beat of a frame waits until the result register is sure to be free
    assign stall    = res_pend | (out_vld_r & ~bus.out_rdy);
    assign in_rdy_c = (state == RUN) && (frames_issued < num_lat)
                      && !((beat_cnt == BEAT_LAST) && stall);
    assign accept   = bus.in_vld & in_rdy_c;
    assign capture  = acc_vld_out & res_pend;
    assign pop      = out_vld_r & bus.out_rdy;

    assign busy         = (state == RUN);
    assign acc_rst      = rst | (state == IDLE);
    assign acc_vld_in   = accept;
    assign acc_data_in  = bus.in_data;
    assign bus.in_rdy   = in_rdy_c;
    assign bus.out_vld  = out_vld_r;
    assign bus.out_last = out_last_r;
    assign bus.out_data = out_data_r;

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            beat_cnt      <= '0;
            num_lat       <= '0;
            frames_issued <= '0;
            frames_done   <= '0;
            res_pend      <= 1'b0;
            out_vld_r     <= 1'b0;
            out_last_r    <= 1'b0;
            out_data_r    <= '0;
            done_pulse    <= 1'b0;
            err           <= 1'b0;
        end else begin
            done_pulse <= 1'b0;
            if (abort) begin
                state      <= IDLE;
                out_vld_r  <= 1'b0;
                out_last_r <= 1'b0;
                res_pend   <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (start) begin
                            err <= 1'b0;
                            if (num_frames != '0) begin
                                state         <= RUN;
                                num_lat       <= num_frames;
                                beat_cnt      <= '0;
                                frames_issued <= '0;
                                frames_done   <= '0;
                            end else begin
                                done_pulse <= 1'b1;
                            end
                        end
                    end
                    RUN: begin
                        if (accept) begin
                            if (beat_cnt == BEAT_LAST) begin
                                beat_cnt      <= '0;
                                frames_issued <= frames_issued + FRAME_CNT_W'(1);
                                res_pend      <= 1'b1;
                            end else begin
                                beat_cnt <= beat_cnt + BCW'(1);
                            end
                        end
                        if (capture) begin
                            out_data_r  <= acc_data_out;
                            out_vld_r   <= 1'b1;
                            res_pend    <= 1'b0;
                            frames_done <= frames_done + FRAME_CNT_W'(1);
                            out_last_r  <= ((frames_done + FRAME_CNT_W'(1)) == num_lat);
                        end else if (pop) begin
                            out_vld_r <= 1'b0;
                        end
                        if (pop && out_last_r) begin
                            state      <= IDLE;
                            done_pulse <= 1'b1;
                            out_last_r <= 1'b0;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
            // a result with nothing pending is flagged and never captured
            if (acc_vld_out && !res_pend) begin
                err <= 1'b1;
            end
        end
    end
endmodule
